// File: rtl/nand_reduce_pipe.sv
// nand_reduce_pipe: two-stage registered bitwise NAND/AND/NOR/OR reduction of NUM_IN words,
// valid/ready on both sides. Define NAND_REDUCE_STATS_EN to add the saturating txn_count output.
module nand_reduce_pipe #(
  parameter int WIDTH  = 8,
  parameter int NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [1:0]              in_mode,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [1:0]              out_mode
`ifdef NAND_REDUCE_STATS_EN
  ,
  output logic [15:0]             txn_count
`endif
);

  typedef enum logic [1:0] {
    MODE_NAND = 2'd0,
    MODE_AND  = 2'd1,
    MODE_NOR  = 2'd2,
    MODE_OR   = 2'd3
  } mode_e;

  if ((NUM_IN < 2) || (NUM_IN > 16)) begin : g_num_in_check
    $error("nand_reduce_pipe: NUM_IN=%0d is outside the legal range 2..16", NUM_IN);
  end

  // Stage 1 registers
  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_and_q,   s1_and_d;
  logic [WIDTH-1:0] s1_or_q,    s1_or_d;
  logic [1:0]       s1_mode_q;

  // Stage 2 (output) registers
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q,  out_data_d;
  logic [1:0]       out_mode_q;

  logic s2_free;
  logic s1_move;
  logic accept;

  assign s2_free  = !out_valid_q || out_ready;
  assign s1_move  = s1_valid_q && s2_free;
  assign in_ready = !s1_valid_q || s2_free;
  assign accept   = in_valid && in_ready;

  // Each result bit sees only its own column of operand bits, so there is no cross-bit logic.
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
    logic [NUM_IN-1:0] col;
    for (genvar gk = 0; gk < NUM_IN; gk++) begin : g_opnd
      assign col[gk] = in_data[gk*WIDTH + gi];
    end
    assign s1_and_d[gi] = &col;
    assign s1_or_d[gi]  = |col;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    if (accept) begin
      s1_valid_d = 1'b1;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    if (s1_move) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    out_data_d = s1_and_q;
    case (mode_e'(s1_mode_q))
      MODE_NAND: out_data_d = ~s1_and_q;
      MODE_AND:  out_data_d = s1_and_q;
      MODE_NOR:  out_data_d = ~s1_or_q;
      MODE_OR:   out_data_d = s1_or_q;
      default:   out_data_d = s1_and_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_and_q   <= '0;
      s1_or_q    <= '0;
      s1_mode_q  <= 2'd0;
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_and_q  <= s1_and_d;
        s1_or_q   <= s1_or_d;
        s1_mode_q <= in_mode;
      end
    end
  end

  // Output data only changes on a move, so a stalled result stays stable for the consumer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mode_q  <= 2'd0;
    end else begin
      out_valid_q <= out_valid_d;
      if (s1_move) begin
        out_data_q <= out_data_d;
        out_mode_q <= s1_mode_q;
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_mode  = out_mode_q;

`ifdef NAND_REDUCE_STATS_EN
  logic [15:0] txn_count_q, txn_count_d;

  always_comb begin
    txn_count_d = txn_count_q;
    if (out_valid_q && out_ready && (txn_count_q != 16'hFFFF)) begin
      txn_count_d = txn_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      txn_count_q <= 16'd0;
    end else begin
      txn_count_q <= txn_count_d;
    end
  end

  assign txn_count = txn_count_q;
`endif

endmodule

// File: tb/tb_nand_reduce_pipe.sv
// Scoreboard bench for nand_reduce_pipe: expected results queued at accept, compared at output.
// Build with NAND_REDUCE_STATS_EN defined to also exercise the txn_count saturation run.
module tb_nand_reduce_pipe;
  localparam int WIDTH  = 8;
  localparam int NUM_IN = 4;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic                    in_valid = 1'b0;
  logic                    in_ready;
  logic [NUM_IN*WIDTH-1:0] in_data = '0;
  logic [1:0]              in_mode = 2'd0;
  logic                    out_valid;
  logic                    out_ready = 1'b1;
  logic [WIDTH-1:0]        out_data;
  logic [1:0]              out_mode;
`ifdef NAND_REDUCE_STATS_EN
  logic [15:0]             txn_count;
`endif

  nand_reduce_pipe #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_mode  (out_mode)
`ifdef NAND_REDUCE_STATS_EN
    ,
    .txn_count (txn_count)
`endif
  );

  always #5 clk = ~clk;

  int chk_cnt  = 0;
  int pass_cnt = 0;
  int acc_cnt  = 0;
  int hs_cnt   = 0;
  int cyc      = 0;
  bit quiet    = 1'b0;
  bit drv_done = 1'b0;
  logic [WIDTH+1:0] sb[$];
  int pop_cyc[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference reduction: {mode, result}
  function automatic logic [WIDTH+1:0] model(input logic [NUM_IN*WIDTH-1:0] d, input logic [1:0] m);
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] o;
    logic [WIDTH-1:0] r;
    a = '1;
    o = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      a = a & d[k*WIDTH +: WIDTH];
      o = o | d[k*WIDTH +: WIDTH];
    end
    case (m)
      2'd0:    r = ~a;
      2'd1:    r = a;
      2'd2:    r = ~o;
      default: r = o;
    endcase
    return {m, r};
  endfunction

  task automatic send(input logic [NUM_IN*WIDTH-1:0] d, input logic [1:0] m);
    int waited;
    bit ok;
    waited = 0;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    while (!ok && waited < 1000) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      else waited++;
    end
    if (ok) begin
      sb.push_back(model(d, m));
      acc_cnt++;
      @(posedge clk);
      #1;
    end else begin
      check_val("send_timeout", 32'd0, 32'd1);
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check_val("drain_empty", 32'(sb.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [NUM_IN*WIDTH-1:0] opnd;
    logic [WIDTH+1:0] exp_v;

    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (!rst && out_valid && out_ready) begin
          if (sb.size() == 0) begin
            check_val("unexpected_out", 32'({out_mode, out_data}), 32'hFFFF_FFFF);
          end else begin
            exp_v = sb.pop_front();
            check_val("out", 32'({out_mode, out_data}), 32'(exp_v));
            if (!quiet) $display("txn out: mode=%0d data=%02h expected mode=%0d data=%02h",
                                 out_mode, out_data, exp_v[WIDTH+1:WIDTH], exp_v[WIDTH-1:0]);
          end
          pop_cyc.push_back(cyc);
          hs_cnt++;
        end
      end
    join_none

    // Reset and idle
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("rst_out_valid", 32'(out_valid), 32'd0);
    check_val("rst_in_ready", 32'(in_ready), 32'd1);
    check_val("rst_out_data", 32'(out_data), 32'h00);
    check_val("rst_out_mode", 32'(out_mode), 32'd0);
    @(posedge clk);
    #1;

    // Latency: all-ones NAND, out_valid exactly two edges after accept
    out_ready = 1'b1;
    send(32'hFFFF_FFFF, 2'd0);
    @(negedge clk);
    check_val("lat_edge1_valid", 32'(out_valid), 32'd0);
    @(negedge clk);
    check_val("lat_edge2_valid", 32'(out_valid), 32'd1);
    wait_drain();

    // Back-to-back modes on the same operands, outputs on consecutive cycles
    pop_cyc.delete();
    opnd = {8'hF5, 8'hFF, 8'h3C, 8'hF0};
    for (int m = 0; m < 4; m++) send(opnd, 2'(m));
    wait_drain();
    check_val("b2b_count", 32'(pop_cyc.size()), 32'd4);
    for (int i = 1; i < pop_cyc.size(); i++) begin
      check_val("b2b_consecutive", 32'(pop_cyc[i] - pop_cyc[i-1]), 32'd1);
    end

    // Back-pressure: two accepted, then in_ready drops; release drains in order
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    acc_cnt = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) send({8'(i), 8'hA5, 8'h5A ^ 8'(i), 8'hFF}, 2'(3 - i));
      end
      begin
        repeat (6) @(negedge clk);
        check_val("bp_accepted", 32'(acc_cnt), 32'd2);
        check_val("bp_in_ready", 32'(in_ready), 32'd0);
        check_val("bp_out_valid", 32'(out_valid), 32'd1);
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    wait_drain();
    check_val("bp_total", 32'(acc_cnt), 32'd4);

    // Reset with two results in flight
    out_ready = 1'b0;
    send(32'h1234_5678, 2'd0);
    send(32'h0F0F_F0F0, 2'd1);
    #3 rst = 1'b1;
    #1;
    check_val("rst_mid_valid", 32'(out_valid), 32'd0);
    check_val("rst_mid_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("post_rst_idle", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    send(32'h8001_C003, 2'd3);
    wait_drain();

    // Random stimulus with random back-pressure
    drv_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 40; i++) send($urandom(), 2'($urandom_range(0, 3)));
        drv_done = 1'b1;
      end
      begin
        while (!drv_done) begin
          @(posedge clk);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();

`ifdef NAND_REDUCE_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    hs_cnt = 0;
    quiet = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 70000; i++) send($urandom(), 2'(i % 4));
    wait_drain();
    @(negedge clk);
    check_val("txn_count_sat", 32'(txn_count), (hs_cnt > 65535) ? 32'h0000_FFFF : 32'(hs_cnt));
    check_val("txn_count_hs", 32'(hs_cnt), 32'd70000);
    rst = 1'b1;
    #1;
    check_val("txn_count_rst", 32'(txn_count), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 1'b0;
`endif

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/nand_reduce_pipe.md
Name: nand_reduce_pipe

Overview:
- Parametrised, registered successor to the two-input combinational NAND cell.
- Reduces NUM_IN operand words of WIDTH bits, bit by bit, using a selectable NAND-family function (NAND/AND/NOR/OR).
- Two-stage pipeline with valid/ready flow control on both sides.
- Sits between operand producers and downstream datapath consumers that need back-pressure-safe logic reduction.

Parameters:
- WIDTH, 8: bits per operand word and result width.
- NUM_IN, 4: operands per transaction; legal range 2..16.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data and in_mode are valid this cycle.
- in_ready  output  1  block accepts a transaction this cycle.
- in_data  input  NUM_IN*WIDTH  operand k occupies bits [k*WIDTH +: WIDTH].
- in_mode  input  2  0=NAND, 1=AND, 2=NOR, 3=OR.
- out_valid  output  1  out_data holds a result.
- out_ready  input  1  consumer takes the result this cycle.
- out_data  output  WIDTH  reduced result.
- out_mode  output  2  mode that produced out_data.

Behaviour:
- Clocking and reset: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values: s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_mode=0. in_ready is 1 from the first cycle after rst deasserts.
- Handshake: a transfer occurs when valid and ready are both 1 on a rising edge. Data is held stable by the sender while valid=1 and ready=0.
- Stage 1 (s1), on accept:
  - s1_and = bitwise AND across all NUM_IN operands.
  - s1_or = bitwise OR across all NUM_IN operands.
  - s1_mode = in_mode.
  - s1_valid = 1.
- Stage 2 (s2 = output register), by s1_mode:
  - NAND: out_data = ~s1_and.
  - AND: out_data = s1_and.
  - NOR: out_data = ~s1_or.
  - OR: out_data = s1_or.
  - out_mode = s1_mode.
- Advance rules:
  - s2_free = !out_valid || out_ready.
  - s1 moves to s2 when s1_valid && s2_free.
  - in_ready = !s1_valid || s2_free. This is combinational, with no path from in_valid.
- Latency and throughput:
  - Exactly 2 clk edges from accept to out_valid=1 when out_ready is held at 1.
  - Full throughput: one transaction per cycle.
- Back-pressure: with out_ready=0, the pipeline holds two results, then in_ready drops to 0. No result is lost or duplicated, and ordering is FIFO.
- Simultaneous events: output pop, s1→s2 move and new accept can all occur in one cycle. All three take effect on the same edge.
- Mode changes apply per transaction only. In-flight results keep the mode they were accepted with.
- Reset mid-operation: all valids clear immediately and asynchronously. In-flight data is discarded, and no out_valid pulse follows reset release.
- Bit independence: each output bit depends only on the same bit index of the operands. No carries.
- Illegal NUM_IN: values outside 2..16 halt elaboration with an error.

Optional Feature:
- NAND_REDUCE_STATS_EN
- Defined:
  - Adds output port txn_count (16 bits): count of output handshakes (out_valid && out_ready).
  - Saturates at 16'hFFFF, never wraps.
  - Resets to 0 on rst.
  - Increments on the same edge as the handshake.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset, then idle 5 cycles → out_valid=0, in_ready=1, out_data=8'h00.
- WIDTH=8, NUM_IN=4, operands {FF,FF,FF,FF}, mode NAND, out_ready=1 → out_data=8'h00, out_mode=0, exactly 2 cycles after accept.
- Operands {F0,3C,FF,F5}, modes NAND/AND/NOR/OR sent back-to-back → 8'hCF, 8'h30, 8'h00, 8'hFF, in that order on consecutive cycles.
- out_ready=0, 4 transactions offered → 2 accepted, then in_ready=0. Release out_ready → all results emerge in order, then the remaining 2 are accepted.
- Assert rst with 2 results in flight → out_valid=0 within the same cycle. After release, out_valid stays 0 until a new accept.
- With NAND_REDUCE_STATS_EN, 70000 handshakes → txn_count=16'hFFFF. Then rst → txn_count=0.
